// File: rtl/zx_bus_initiator.sv
// Z80-style bus master: turns valid/ready commands into ZX Spectrum edge-connector
// memory/IO cycles (T1, T2, optional TWA/TW waits, T3) and returns a one-cycle response.
`timescale 1ns/1ps
module zx_bus_initiator #(
    parameter int CLK_PER_T = 1,
    parameter int MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_io,
    input  logic        cmd_wr,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        mreq_n,
    output logic        iorq_n,
    output logic        rd_n,
    output logic        wr_n,
    input  logic        wait_n
);

    localparam int                TCNT_W    = (CLK_PER_T > 1) ? $clog2(CLK_PER_T) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(CLK_PER_T - 1);
    localparam logic [7:0]        WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_TWA,
        S_TW,
        S_T3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TCNT_W-1:0] r_tcnt;
    logic [7:0]        r_wait_cnt;
    logic              r_io;
    logic              r_wr;
    logic              w_accept;
    logic              w_last;
    logic              w_abort;
    logic              w_done;
    logic              w_strobe_nxt;

    assign cmd_ready    = (r_state == S_IDLE);
    assign w_accept     = (r_state == S_IDLE) && cmd_valid;
    assign w_last       = (r_tcnt == TCNT_LAST);
    assign w_done       = (r_state == S_T3) && w_last;
    assign w_strobe_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_T1);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: if (cmd_valid) w_state_nxt = S_T1;
            S_T1:   if (w_last) w_state_nxt = S_T2;
            S_T2: begin
                if (w_last) begin
                    if (r_io)        w_state_nxt = S_TWA;
                    else if (wait_n) w_state_nxt = S_T3;
                    else             w_state_nxt = S_TW;
                end
            end
            S_TWA:  if (w_last) w_state_nxt = wait_n ? S_T3 : S_TW;
            S_TW: begin
                if (w_last) begin
                    if (wait_n) begin
                        w_state_nxt = S_T3;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_abort     = 1'b1;
                    end
                end
            end
            S_T3:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt     <= '0;
            r_wait_cnt <= '0;
            r_io       <= 1'b0;
            r_wr       <= 1'b0;
            A          <= '0;
            D_out      <= '0;
            D_oe       <= 1'b0;
            mreq_n     <= 1'b1;
            iorq_n     <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            r_tcnt <= ((r_state == S_IDLE) || w_last) ? '0 : r_tcnt + 1'b1;

            if (r_state != S_TW)  r_wait_cnt <= '0;
            else if (w_last)      r_wait_cnt <= r_wait_cnt + 1'b1;

            if (w_accept) begin
                A     <= cmd_addr;
                r_io  <= cmd_io;
                r_wr  <= cmd_wr;
                D_out <= cmd_wr ? cmd_wdata : 8'h00;
                D_oe  <= cmd_wr;
            end else if (w_state_nxt == S_IDLE) begin
                D_oe  <= 1'b0;
            end

            // Strobes decode the next state so they fall exactly at the T1->T2 edge.
            mreq_n <= !(w_strobe_nxt && !r_io);
            iorq_n <= !(w_strobe_nxt &&  r_io);
            rd_n   <= !(w_strobe_nxt && !r_wr);
            wr_n   <= !(w_strobe_nxt &&  r_wr);

            rsp_valid <= w_done || w_abort;
            if (w_done) begin
                rsp_data <= r_wr ? 8'h00 : D_in;
                rsp_err  <= 1'b0;
            end else if (w_abort) begin
                rsp_data <= 8'h00;
                rsp_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_zx_bus_initiator.sv
// Bench for zx_bus_initiator: two instances (1 and 3 clocks per T-state) checked
// every cycle against a phase-list model of the expected bus waveform.
`timescale 1ns/1ps
module tb_zx_bus_initiator;

    localparam int P0 = 1, M0 = 4;
    localparam int P1 = 3, M1 = 5;

    typedef struct {
        bit          chk;
        int          d;
        bit          cv, io, wr;
        logic [15:0] addr;
        logic [7:0]  wd, din;
        bit          wn;
        bit          ready, busy;
        logic [15:0] a;
        bit          mreq_n, iorq_n, rd_n, wr_n, d_oe;
        logic [7:0]  d_out;
        bit          rv;
        logic [7:0]  rdata;
        bit          rerr;
    } rec_t;

    logic clk;
    logic reset;
    logic sel;
    logic cv, c_io, c_wr, wait_n;
    logic [15:0] c_addr;
    logic [7:0]  c_wd, d_in;
    logic cv0, cv1;

    logic        rdy    [2];
    logic        rv_o   [2];
    logic [7:0]  rdat_o [2];
    logic        rerr_o [2];
    logic [15:0] a_o    [2];
    logic [7:0]  dout_o [2];
    logic        doe_o  [2];
    logic        mreq_o [2];
    logic        iorq_o [2];
    logic        rd_o   [2];
    logic        wr_o   [2];

    rec_t        q[$];
    int          n_tests, n_fail;
    int          obs_low, obs_rsp;
    int          fixed_din;
    bit          pend_v   [2];
    logic [7:0]  pend_data[2];
    bit          pend_err [2];
    logic [7:0]  held_data[2];
    bit          held_err [2];

    assign cv0 = cv & ~sel;
    assign cv1 = cv & sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    zx_bus_initiator #(.CLK_PER_T(P0), .MAX_WAIT(M0)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cv0), .cmd_ready(rdy[0]),
        .cmd_io(c_io), .cmd_wr(c_wr), .cmd_addr(c_addr), .cmd_wdata(c_wd),
        .rsp_valid(rv_o[0]), .rsp_data(rdat_o[0]), .rsp_err(rerr_o[0]),
        .A(a_o[0]), .D_out(dout_o[0]), .D_oe(doe_o[0]), .D_in(d_in),
        .mreq_n(mreq_o[0]), .iorq_n(iorq_o[0]), .rd_n(rd_o[0]), .wr_n(wr_o[0]),
        .wait_n(wait_n)
    );

    zx_bus_initiator #(.CLK_PER_T(P1), .MAX_WAIT(M1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cv1), .cmd_ready(rdy[1]),
        .cmd_io(c_io), .cmd_wr(c_wr), .cmd_addr(c_addr), .cmd_wdata(c_wd),
        .rsp_valid(rv_o[1]), .rsp_data(rdat_o[1]), .rsp_err(rerr_o[1]),
        .A(a_o[1]), .D_out(dout_o[1]), .D_oe(doe_o[1]), .D_in(d_in),
        .mreq_n(mreq_o[1]), .iorq_n(iorq_o[1]), .rd_n(rd_o[1]), .wr_n(wr_o[1]),
        .wait_n(wait_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // An IDLE cycle; consumes a pending response so the pulse lands on the first IDLE clock.
    function automatic rec_t idle_rec(input int d);
        rec_t r;
        r.chk = 1'b1; r.d = d;
        r.cv = 1'b0; r.io = 1'($urandom); r.wr = 1'($urandom);
        r.addr = 16'($urandom); r.wd = 8'($urandom); r.din = 8'($urandom); r.wn = 1'($urandom);
        r.ready = 1'b1; r.busy = 1'b0; r.a = '0;
        r.mreq_n = 1'b1; r.iorq_n = 1'b1; r.rd_n = 1'b1; r.wr_n = 1'b1;
        r.d_oe = 1'b0; r.d_out = '0;
        r.rv = pend_v[d];
        if (pend_v[d]) begin
            held_data[d] = pend_data[d];
            held_err[d]  = pend_err[d];
            pend_v[d]    = 1'b0;
        end
        r.rdata = held_data[d]; r.rerr = held_err[d];
        return r;
    endfunction

    task automatic step(input rec_t r);
        sel = (r.d != 0); cv = r.cv; c_io = r.io; c_wr = r.wr;
        c_addr = r.addr; c_wd = r.wd; d_in = r.din; wait_n = r.wn;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    // One bus cycle with w low wait_n samples; optional async reset in the first T2 clock.
    task automatic do_txn(input int d, input bit io, input bit wr, input logic [15:0] addr,
                          input logic [7:0] wd, input int w, input bit rst_t2);
        rec_t       r;
        int         p, mx, n_tw, samp, kinds[$];
        bit         abort, sampler, strobe;
        logic [7:0] last_din;
        p = (d != 0) ? P1 : P0;
        mx = (d != 0) ? M1 : M0;
        abort = (w > mx);
        n_tw = abort ? mx : w;
        kinds = {0, 1};                        // 0=T1 1=T2 2=TWA 3=TW 4=T3
        if (io) kinds.push_back(2);
        repeat (n_tw) kinds.push_back(3);
        if (!abort) kinds.push_back(4);
        last_din = '0;

        r = idle_rec(d);
        r.cv = 1'b1; r.io = io; r.wr = wr; r.addr = addr; r.wd = wd;
        step(r);

        samp = 0;
        foreach (kinds[k]) begin
            sampler = (kinds[k] == 3) || (kinds[k] == 2) || (kinds[k] == 1 && !io);
            strobe  = (kinds[k] != 0);
            if (sampler) samp++;
            for (int c = 0; c < p; c++) begin
                r.chk = 1'b1; r.d = d;
                r.cv = 1'($urandom); r.io = 1'($urandom); r.wr = 1'($urandom);
                r.addr = 16'($urandom); r.wd = 8'($urandom);
                r.din = (fixed_din >= 0) ? 8'(fixed_din) : 8'($urandom);
                r.wn = 1'($urandom);
                if (c == p - 1) begin
                    if (sampler) r.wn = (samp <= w) ? 1'b0 : 1'b1;
                    if (kinds[k] == 4) last_din = r.din;
                end
                r.ready = 1'b0; r.busy = 1'b1; r.a = addr;
                r.mreq_n = !(strobe && !io); r.iorq_n = !(strobe && io);
                r.rd_n = !(strobe && !wr);   r.wr_n = !(strobe && wr);
                r.d_oe = wr; r.d_out = wd;
                r.rv = 1'b0; r.rdata = held_data[d]; r.rerr = held_err[d];
                if (rst_t2 && kinds[k] == 1) begin
                    r.chk = 1'b0;
                    sel = (d != 0); cv = r.cv; d_in = r.din; wait_n = r.wn;
                    q.push_back(r);
                    #2;
                    check("pre_rst_mreq_n", 32'(mreq_o[d]), 32'(0));
                    check("pre_rst_wr_n", 32'(wr_o[d]), 32'(0));
                    check("pre_rst_d_oe", 32'(doe_o[d]), 32'(1));
                    reset = 1'b1;
                    #1;
                    check("rst_mreq_n", 32'(mreq_o[d]), 32'(1));
                    check("rst_wr_n", 32'(wr_o[d]), 32'(1));
                    check("rst_d_oe", 32'(doe_o[d]), 32'(0));
                    check("rst_rsp_valid", 32'(rv_o[d]), 32'(0));
                    check("rst_ready", 32'(rdy[d]), 32'(1));
                    @(negedge clk);
                    reset = 1'b0;
                    for (int i = 0; i < 2; i++) begin
                        pend_v[i] = 1'b0; held_data[i] = '0; held_err[i] = 1'b0;
                    end
                    @(posedge clk);
                    #1;
                    return;
                end
                step(r);
            end
        end
        pend_v[d]    = 1'b1;
        pend_data[d] = abort ? 8'h00 : (wr ? 8'h00 : last_din);
        pend_err[d]  = abort;
    endtask

    initial begin : compare
        rec_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    check("cmd_ready", 32'(rdy[e.d]), 32'(e.ready));
                    check("mreq_n", 32'(mreq_o[e.d]), 32'(e.mreq_n));
                    check("iorq_n", 32'(iorq_o[e.d]), 32'(e.iorq_n));
                    check("rd_n", 32'(rd_o[e.d]), 32'(e.rd_n));
                    check("wr_n", 32'(wr_o[e.d]), 32'(e.wr_n));
                    check("D_oe", 32'(doe_o[e.d]), 32'(e.d_oe));
                    if (e.busy) check("A", 32'(a_o[e.d]), 32'(e.a));
                    if (e.d_oe) check("D_out", 32'(dout_o[e.d]), 32'(e.d_out));
                    check("rsp_valid", 32'(rv_o[e.d]), 32'(e.rv));
                    check("rsp_data", 32'(rdat_o[e.d]), 32'(e.rdata));
                    check("rsp_err", 32'(rerr_o[e.d]), 32'(e.rerr));
                    if (!mreq_o[e.d] || !iorq_o[e.d] || !rd_o[e.d] || !wr_o[e.d]) obs_low++;
                    if (rv_o[e.d]) obs_rsp++;
                end
            end
        end
    end

    initial begin : stim
        n_tests = 0; n_fail = 0; obs_low = 0; obs_rsp = 0; fixed_din = -1;
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0; pend_data[i] = '0; pend_err[i] = 1'b0;
            held_data[i] = '0; held_err[i] = 1'b0;
        end
        reset = 1'b1; sel = 1'b0; cv = 1'b0; c_io = 1'b0; c_wr = 1'b0;
        c_addr = '0; c_wd = '0; d_in = '0; wait_n = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            check("reset_A", 32'(a_o[d]), 32'(0));
            check("reset_strobes", 32'({mreq_o[d], iorq_o[d], rd_o[d], wr_o[d]}), 32'(4'hF));
            check("reset_D", 32'({doe_o[d], dout_o[d]}), 32'(0));
            check("reset_rsp", 32'({rv_o[d], rerr_o[d], rdat_o[d]}), 32'(0));
            check("reset_ready", 32'(rdy[d]), 32'(1));
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(idle_rec(0));

        // IO write to 0x007F: strobes low T2,TWA,T3 = 3 clocks, one response.
        obs_low = 0; obs_rsp = 0;
        do_txn(0, 1'b1, 1'b1, 16'h007F, 8'h00, 0, 1'b0);
        step(idle_rec(0));
        check("io_wr_low_clocks", 32'(obs_low), 32'(3));
        check("io_wr_rsp_count", 32'(obs_rsp), 32'(1));

        // Memory read of 0x0000 with fixed bus data.
        obs_low = 0; fixed_din = 8'hA5;
        do_txn(0, 1'b0, 1'b0, 16'h0000, 8'h00, 0, 1'b0);
        step(idle_rec(0));
        fixed_din = -1;
        check("mem_rd_low_clocks", 32'(obs_low), 32'(2));
        check("mem_rd_data", 32'(rdat_o[0]), 32'(8'hA5));
        check("mem_rd_err", 32'(rerr_o[0]), 32'(0));

        // Three wait samples: three TW states.
        obs_low = 0;
        do_txn(0, 1'b0, 1'b0, 16'h1234, 8'h00, 3, 1'b0);
        step(idle_rec(0));
        check("wait3_low_clocks", 32'(obs_low), 32'(5));

        // Stuck wait on IO read: abort after MAX_WAIT TW states.
        obs_low = 0;
        do_txn(0, 1'b1, 1'b0, 16'h00FE, 8'h00, 9, 1'b0);
        step(idle_rec(0));
        check("timeout_low_clocks", 32'(obs_low), 32'(6));
        check("timeout_err", 32'(rerr_o[0]), 32'(1));
        check("timeout_data", 32'(rdat_o[0]), 32'(0));

        // Exactly MAX_WAIT low samples: completes without abort.
        obs_low = 0;
        do_txn(0, 1'b1, 1'b0, 16'h007F, 8'h00, M0, 1'b0);
        step(idle_rec(0));
        check("maxwait_low_clocks", 32'(obs_low), 32'(7));
        check("maxwait_err", 32'(rerr_o[0]), 32'(0));

        // Reset during T2 of a memory write, then a normal cycle.
        obs_rsp = 0;
        do_txn(0, 1'b0, 1'b1, 16'h4000, 8'h5A, 0, 1'b1);
        step(idle_rec(0));
        do_txn(0, 1'b0, 1'b1, 16'h4001, 8'hC3, 1, 1'b0);
        step(idle_rec(0));
        check("post_reset_rsp_count", 32'(obs_rsp), 32'(1));

        for (int i = 0; i < 40; i++) begin
            do_txn(0, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                   $urandom_range(6, 0), 1'b0);
            repeat ($urandom_range(2, 0)) step(idle_rec(0));
        end
        step(idle_rec(0));

        // Three clocks per T-state: back-to-back IO write then memory read.
        step(idle_rec(1));
        obs_low = 0; obs_rsp = 0;
        do_txn(1, 1'b1, 1'b1, 16'h007F, 8'h3C, 0, 1'b0);
        do_txn(1, 1'b0, 1'b0, 16'h0100, 8'h00, 0, 1'b0);
        step(idle_rec(1));
        check("p3_b2b_low_clocks", 32'(obs_low), 32'(15));
        check("p3_b2b_rsp_count", 32'(obs_rsp), 32'(2));

        for (int i = 0; i < 20; i++) begin
            do_txn(1, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
                   $urandom_range(7, 0), 1'b0);
            repeat ($urandom_range(2, 0)) step(idle_rec(1));
        end
        step(idle_rec(1));
        step(idle_rec(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zx_bus_initiator.md
Name: zx_bus_initiator

Overview:
- Clocked Z80-style bus master that turns simple commands into ZX Spectrum edge-connector cycles on mreq_n/iorq_n/rd_n/wr_n/address/data.
- Drives the same bus the cartridge decoder listens on: page-up IO writes with A7=0, and lower-ROM memory reads.
- Used as a bench/bring-up host and FPGA-side exerciser for cartridge logic.
- Command in via valid/ready; completion returned as a one-cycle response pulse.

Parameters:
CLK_PER_T, 1, clocks per Z80 T-state (1..16)
MAX_WAIT, 255, maximum inserted wait states before abort (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE; command accepted on edge where cmd_valid&&cmd_ready
cmd_io  in  1  1=IO cycle, 0=memory cycle
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  16  bus address
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  8  read data captured in T3 (0x00 for writes)
rsp_err  out  1  valid with rsp_valid; 1=wait timeout abort
A  out  16  address bus
D_out  out  8  data to bus
D_oe  out  1  data bus drive enable
D_in  in  8  data from bus
mreq_n  out  1  memory request, active low
iorq_n  out  1  IO request, active low
rd_n  out  1  read strobe, active low
wr_n  out  1  write strobe, active low
wait_n  in  1  wait request, active low

Behaviour:
- Reset (async, immediate): state IDLE; A=0; D_out=0; D_oe=0; mreq_n=iorq_n=rd_n=wr_n=1; rsp_valid=0; rsp_data=0; rsp_err=0; T-state and wait counters 0.
- States: IDLE, T1, T2, TWA (automatic IO wait), TW, T3. Each non-IDLE state lasts exactly CLK_PER_T clocks, counted by a T-counter.
- Accept: in IDLE with cmd_valid=1, latch the command, go to T1; A=cmd_addr registered on the accept edge, held until return to IDLE.
- Writes: D_out=cmd_wdata, D_oe=1 from T1 through T3; D_oe=0 in IDLE.
- T1: all strobes high. T1->T2.
- Memory cycle: mreq_n and (rd_n or wr_n) low throughout T2, TW, T3.
- IO cycle: iorq_n and (rd_n or wr_n) low throughout T2, TWA, TW, T3; mreq_n stays high.
- Memory: T2 -> TW if wait_n=0 on the last clock of T2, else T3.
- IO: T2 -> TWA always; TWA -> TW/T3 on wait_n sampled on the last clock of TWA.
- TW: re-sample wait_n on the last clock of each TW; stay in TW while it is 0.
- Timeout: if the wait counter reaches MAX_WAIT with wait_n still 0, go directly to IDLE and release all strobes; rsp_valid=1, rsp_err=1, rsp_data=0.
- T3: on its last clock, rsp_data<=D_in for reads, 0 for writes; rsp_err<=0; -> IDLE.
- Response: rsp_valid=1 for exactly the first IDLE clock after T3 or abort; rsp_data/rsp_err hold until the next response.
- Back-to-back: cmd_ready=1 in that same IDLE clock, so the minimum gap between cycles is one IDLE clock.
- No overlap between cycles; command inputs are ignored outside IDLE.
- Strobes are registered outputs (glitch-free); address is stable one full T-state before any strobe falls.
- Reset mid-cycle: strobes released asynchronously; the command is dropped with no rsp_valid.

Test Plan (CLK_PER_T=1 unless stated):
- IO write: A=0x007F, wdata=0x00, accepted at edge k -> iorq_n and wr_n low exactly clocks k+2..k+4 (3 clocks); mreq_n=1 throughout; A=0x007F k+1..k+4; rsp_valid at k+5 with rsp_err=0.
- Memory read: A=0x0000, D_in=0xA5, wait_n=1 -> mreq_n and rd_n low 2 clocks; rd_n never low in T1; rsp_data=0xA5, rsp_err=0; cmd_ready returns high with rsp_valid.
- Wait insertion: memory read with wait_n=0 for 3 samples -> 3 TW states; strobes low 5 clocks; read data taken from the T3 clock only.
- Timeout: MAX_WAIT=4, wait_n stuck 0 on an IO read -> abort after 4 TW; all strobes high; rsp_valid=1, rsp_err=1, rsp_data=0x00.
- Reset mid-cycle: assert reset during T2 of a memory write -> mreq_n, wr_n and D_oe deassert in the same clock; no rsp_valid; next command runs normally.
- CLK_PER_T=3, back-to-back IO write then memory read with cmd_valid held -> each T-state 3 clocks; exactly one IDLE clock between cycles; two rsp_valid pulses.
